move_cmd_exec: RTL



---
 rtl/move_cmd_exec.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/move_cmd_exec.sv
// Command consumer for the maze robot: decodes calibrate / move / tour-start commands,
// steers heading, ramps forward speed and counts centre-line crossings to stop after N squares.
module move_cmd_exec #(
    parameter logic [9:0]  FRWRD_INC  = 10'h010,
    parameter logic [9:0]  MAX_SPD    = 10'h2A0,
    parameter logic [11:0] ERR_THRESH = 12'h030
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic        strt_cal,
    input  logic        cal_done,
    output logic        tour_go,
    output logic        fanfare_go,
    output logic [11:0] desired_heading,
    input  logic [11:0] error,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    output logic        moving,
    output logic [9:0]  frwrd
);

    localparam logic [2:0] OP_CAL  = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b010;
    localparam logic [2:0] OP_TOUR = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAL,
        S_TURN,
        S_RAMP_UP,
        S_RAMP_DOWN
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [9:0]  r_frwrd;
    logic [11:0] r_desired_heading;
    logic [4:0]  r_line_cnt;
    logic        r_cntr_ir_ff;
    logic        r_fanfare_q;
    logic [3:0]  r_squares_q;

    logic [2:0]  w_opcode;
    logic        w_accept;
    logic        w_accept_move;
    logic        w_in_move;
    logic [11:0] w_err_mag;
    logic        w_err_ok;
    logic        w_ir_rise;
    logic        w_at_goal;
    logic        w_ramp_en;
    logic [10:0] w_frwrd_sum;
    logic [9:0]  w_frwrd_up;
    logic [9:0]  w_dec_step;
    logic [9:0]  w_frwrd_dn;

    assign w_opcode      = cmd[15:13];
    assign w_accept      = (r_state == S_IDLE) && cmd_rdy;
    assign w_accept_move = w_accept && (w_opcode == OP_MOVE);
    assign w_in_move     = (r_state == S_TURN) || (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);

    // Two's-complement magnitude; 12'h800 maps to itself, i.e. 2048 unsigned, the largest value.
    assign w_err_mag = error[11] ? (~error + 12'd1) : error;
    assign w_err_ok  = (w_err_mag < ERR_THRESH);

    assign w_ir_rise = cntrIR & ~r_cntr_ir_ff;
    assign w_at_goal = (r_line_cnt == {r_squares_q, 1'b0});
    // A zero-square move must stop without ever picking up speed.
    assign w_ramp_en = (r_squares_q != 4'd0);

    assign w_frwrd_sum = {1'b0, r_frwrd} + {1'b0, FRWRD_INC};
    assign w_frwrd_up  = (w_frwrd_sum > {1'b0, MAX_SPD}) ? MAX_SPD : w_frwrd_sum[9:0];
    assign w_dec_step  = {FRWRD_INC[8:0], 1'b0};
    assign w_frwrd_dn  = (r_frwrd < w_dec_step) ? 10'd0 : (r_frwrd - w_dec_step);

    assign frwrd           = r_frwrd;
    assign desired_heading = r_desired_heading;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output is given a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        clr_cmd_rdy  = 1'b0;
        strt_cal     = 1'b0;
        tour_go      = 1'b0;
        send_resp    = 1'b0;
        fanfare_go   = 1'b0;
        moving       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    case (w_opcode)
                        OP_CAL: begin
                            strt_cal     = 1'b1;
                            w_next_state = S_CAL;
                        end
                        OP_MOVE: w_next_state = S_TURN;
                        OP_TOUR: tour_go = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_CAL: begin
                if (cal_done) begin
                    send_resp    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_TURN: begin
                moving = 1'b1;
                if (w_err_ok) begin
                    w_next_state = S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                moving = 1'b1;
                if (w_at_goal) begin
                    w_next_state = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                moving = 1'b1;
                if (r_frwrd == 10'd0) begin
                    send_resp    = 1'b1;
                    fanfare_go   = r_fanfare_q;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frwrd           <= 10'd0;
            r_desired_heading <= 12'd0;
            r_line_cnt        <= 5'd0;
            r_cntr_ir_ff      <= 1'b0;
            r_fanfare_q       <= 1'b0;
            r_squares_q       <= 4'd0;
        end else begin
            r_cntr_ir_ff <= cntrIR;
            if (w_accept_move) begin
                r_fanfare_q       <= cmd[12];
                r_squares_q       <= cmd[3:0];
                r_desired_heading <= (cmd[11:4] == 8'd0) ? 12'h000 : {cmd[11:4], 4'hF};
                r_frwrd           <= 10'd0;
                r_line_cnt        <= 5'd0;
            end else begin
                if (w_in_move && w_ir_rise && (r_line_cnt != 5'd31)) begin
                    r_line_cnt <= r_line_cnt + 5'd1;
                end
                // Ramp follows the current state even on the cycle the state changes.
                case (r_state)
                    S_RAMP_UP: begin
                        if (heading_rdy && w_ramp_en) begin
                            r_frwrd <= w_frwrd_up;
                        end
                    end
                    S_RAMP_DOWN: begin
                        if (heading_rdy) begin
                            r_frwrd <= w_frwrd_dn;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
